ft232h_fifo_model: RTL

Synthesizable device-side model of the FT232H in 245 synchronous FIFO mode: the chip end of the `ft232h_simple` bus.
- Presents `rxf_n`, `txe_n` and the data bus to the FPGA-side controller.
- Buffers host→FPGA bytes (RX) and FPGA→host bytes (TX) in two internal FIFOs, with a simple host-side streaming port on each.
- Used in simulation benches and in loopback builds; checks controller handshake legality and flags violations.

---
 rtl/ft232h_pkg.sv | 12 +
 rtl/ft232h_sync_fifo.sv | 69 ++++++
 rtl/ft232h_fifo_model.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ft232h_pkg.sv
// Shared constants for the FT232H 245 synchronous FIFO device model.
package ft232h_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_WR_FULL    = 3'd1;
  localparam logic [2:0] ERR_RD_NOOE    = 3'd2;
  localparam logic [2:0] ERR_RD_EMPTY   = 3'd3;
  localparam logic [2:0] ERR_CONTENTION = 3'd4;

endpackage

// File: rtl/ft232h_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and next-state count.
// The head reads as zero while the FIFO is empty so the bus idles at 0.
module ft232h_sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_next
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Next occupancy: unchanged when push and pop coincide.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/ft232h_fifo_model.sv
// Device-side model of the FT232H in 245 synchronous FIFO mode.
// RX carries host bytes to the FPGA, TX carries FPGA bytes to the host;
// controller strobes are qualified here and illegal ones are flagged and dropped.
module ft232h_fifo_model
  import ft232h_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              oe_n,
  input  logic              siwu_n,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] data_o,
  output logic              data_oe,
  output logic              rxf_n,
  output logic              txe_n,
  input  logic              host_rx_valid,
  input  logic [BYTE_W-1:0] host_rx_data,
  output logic              host_rx_ready,
  output logic              host_tx_valid,
  output logic [BYTE_W-1:0] host_tx_data,
  input  logic              host_tx_ready,
  output logic              flush,
  output logic              proto_err,
  output logic [2:0]        err_code
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2:0] rx_count;
  logic [DEPTH_LOG2:0] rx_count_next;
  logic [DEPTH_LOG2:0] tx_count;
  logic [DEPTH_LOG2:0] tx_count_next;
  logic                rx_empty;
  logic                rx_push;
  logic                rx_pop;
  logic                tx_push;
  logic                tx_pop;
  logic [2:0]          viol_code;
  logic                siwu_q;

  assign rx_empty      = (rx_count == '0);
  assign host_rx_ready = (rx_count != FULL_COUNT);
  assign host_tx_valid = (tx_count != '0);

  assign rx_push = host_rx_valid & host_rx_ready;
  assign tx_pop  = host_tx_valid & host_tx_ready;
  // A read is only honoured with the bus turned toward the FPGA, data present and no write contending.
  assign rx_pop  = ~rd_n & ~oe_n & ~rx_empty & wr_n;
  // A write is only honoured with space available and the model not asked to drive the bus.
  assign tx_push = ~wr_n & ~txe_n & oe_n;

  assign flush = siwu_q & ~siwu_n;

  ft232h_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (BYTE_W)
  ) u_rx_fifo (
    .clock      (clock),
    .rst        (rst),
    .push       (rx_push),
    .push_data  (host_rx_data),
    .pop        (rx_pop),
    .head       (data_o),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

  ft232h_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (BYTE_W)
  ) u_tx_fifo (
    .clock      (clock),
    .rst        (rst),
    .push       (tx_push),
    .push_data  (data_i),
    .pop        (tx_pop),
    .head       (host_tx_data),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

  // Classify this cycle's strobes; the lowest-numbered violation wins when several apply.
  always_comb begin
    viol_code = ERR_NONE;
    if (!wr_n && txe_n) begin
      viol_code = ERR_WR_FULL;
    end else if (!rd_n && oe_n) begin
      viol_code = ERR_RD_NOOE;
    end else if (!rd_n && rx_empty) begin
      viol_code = ERR_RD_EMPTY;
    end else if (!wr_n && !oe_n) begin
      viol_code = ERR_CONTENTION;
    end
  end

  // Status flags follow next-state counts so they move on the edge that empties or fills.
  always_ff @(posedge clock) begin
    if (rst) begin
      rxf_n   <= 1'b1;
      txe_n   <= 1'b0;
      data_oe <= 1'b0;
      siwu_q  <= 1'b1;
    end else begin
      rxf_n   <= (rx_count_next == '0);
      txe_n   <= (tx_count_next == FULL_COUNT);
      data_oe <= ~oe_n;
      siwu_q  <= siwu_n;
    end
  end

  // Sticky error latch keeping the cause of the first violation only.
  always_ff @(posedge clock) begin
    if (rst) begin
      proto_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (viol_code != ERR_NONE && !proto_err) begin
      proto_err <= 1'b1;
      err_code  <= viol_code;
    end
  end

endmodule
